// File: rtl/hazard_ctrl_if.sv
// Hazard-unit bundle: pipeline-stage register addresses and hazard events in,
// stall/flush/forward controls out.
interface hazard_ctrl_if #(
   parameter int ADDR_W = 4
);
   logic [ADDR_W-1:0] RA1D, RA2D, RA1E, RA2E;
   logic [ADDR_W-1:0] WA3E, WA3M, WA3W;
   logic              RegWriteM, RegWriteW;
   logic              MemtoRegE, MulStartE, BranchTakenE;
   logic              PCWrPendingF, PCSrcW;
   logic [1:0]        ForwardAE, ForwardBE;
   logic              StallF, StallD, StallE;
   logic              FlushD, FlushE, FlushM;
   logic              MulBusy, MulDone;

   modport master (
      output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
      output RegWriteM, RegWriteW, MemtoRegE, MulStartE, BranchTakenE,
      output PCWrPendingF, PCSrcW,
      input  ForwardAE, ForwardBE, StallF, StallD, StallE,
      input  FlushD, FlushE, FlushM, MulBusy, MulDone
   );

   modport slave (
      input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
      input  RegWriteM, RegWriteW, MemtoRegE, MulStartE, BranchTakenE,
      input  PCWrPendingF, PCSrcW,
      output ForwardAE, ForwardBE, StallF, StallD, StallE,
      output FlushD, FlushE, FlushM, MulBusy, MulDone
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard unit for the 5-stage core: forwarding selects, stage stalls/flushes, and an
// FSM that holds a multi-cycle multiply in Execute for MUL_LAT cycles.
module hazard_ctrl #(
   parameter int MUL_LAT = 4
) (
   input logic          clk,
   input logic          reset,
   hazard_ctrl_if.slave hz
);
   localparam int CNT_W = $clog2(MUL_LAT) + 1;
   localparam logic [CNT_W-1:0] CNT_INIT = (MUL_LAT > 1) ? CNT_W'(MUL_LAT - 2) : '0;

   typedef enum logic {StIdle, StBusy} state_e;

   state_e           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic             w_mul_stall, w_mul_done, w_ldr_stall, w_run;
   logic [1:0]       w_fwd_a, w_fwd_b;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= StIdle;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // MulStartE is ignored in StBusy: the same multiply is still held in E.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      unique case (r_state)
         StIdle: begin
            if (hz.MulStartE && (MUL_LAT > 1)) begin
               w_state_nxt = StBusy;
               w_cnt_nxt   = CNT_INIT;
            end
         end
         StBusy: begin
            if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end else begin
               w_state_nxt = StIdle;
            end
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   always_comb begin
      w_mul_stall = 1'b0;
      w_mul_done  = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (hz.MulStartE) begin
               if (MUL_LAT == 1) w_mul_done  = 1'b1;
               else              w_mul_stall = 1'b1;
            end
         end
         StBusy: begin
            if (r_cnt != '0) w_mul_stall = 1'b1;
            else             w_mul_done  = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      w_fwd_a = 2'b00;
      if (hz.RegWriteM && (hz.RA1E == hz.WA3M))      w_fwd_a = 2'b10;
      else if (hz.RegWriteW && (hz.RA1E == hz.WA3W)) w_fwd_a = 2'b01;
      w_fwd_b = 2'b00;
      if (hz.RegWriteM && (hz.RA2E == hz.WA3M))      w_fwd_b = 2'b10;
      else if (hz.RegWriteW && (hz.RA2E == hz.WA3W)) w_fwd_b = 2'b01;
   end

   assign w_ldr_stall = hz.MemtoRegE && ((hz.RA1D == hz.WA3E) || (hz.RA2D == hz.WA3E));

   // Every combinational output is forced low while reset is held.
   assign w_run = ~reset;

   assign hz.ForwardAE = w_run ? w_fwd_a : 2'b00;
   assign hz.ForwardBE = w_run ? w_fwd_b : 2'b00;
   assign hz.StallE    = w_run & w_mul_stall;
   assign hz.StallF    = w_run & (w_ldr_stall | w_mul_stall | hz.PCWrPendingF);
   assign hz.StallD    = w_run & (w_ldr_stall | w_mul_stall | hz.PCWrPendingF);
   assign hz.FlushM    = w_run & w_mul_stall;
   assign hz.FlushD    = w_run & (hz.PCWrPendingF | hz.PCSrcW | hz.BranchTakenE);
   assign hz.FlushE    = w_run & (w_ldr_stall | hz.BranchTakenE) & ~w_mul_stall;
   assign hz.MulBusy   = (r_state == StBusy);
   assign hz.MulDone   = w_run & w_mul_done;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a MUL_LAT=4 instance and a MUL_LAT=1 instance.
module tb_hazard_ctrl;
   logic clk;
   logic reset;

   hazard_ctrl_if #(.ADDR_W(4)) m_if ();
   hazard_ctrl_if #(.ADDR_W(4)) s_if ();

   hazard_ctrl #(.MUL_LAT(4)) u_dut (.clk(clk), .reset(reset), .hz(m_if));
   hazard_ctrl #(.MUL_LAT(1)) u_dut1 (.clk(clk), .reset(reset), .hz(s_if));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      bit          sel;
      logic [11:0] exp;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // {ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM, MulBusy, MulDone}
   logic [11:0] act_m, act_s;
   assign act_m = {m_if.ForwardAE, m_if.ForwardBE, m_if.StallF, m_if.StallD, m_if.StallE,
                   m_if.FlushD, m_if.FlushE, m_if.FlushM, m_if.MulBusy, m_if.MulDone};
   assign act_s = {s_if.ForwardAE, s_if.ForwardBE, s_if.StallF, s_if.StallD, s_if.StallE,
                   s_if.FlushD, s_if.FlushE, s_if.FlushM, s_if.MulBusy, s_if.MulDone};

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t        e;
         logic [11:0] a;
         e = q.pop_front();
         a = e.sel ? act_s : act_m;
         n_checks++;
         if (a !== e.exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", e.name, a, e.exp);
         end
      end
   end

   function automatic logic [11:0] ev(input logic [1:0] fa, input logic [1:0] fb,
                                      input bit sf, input bit sd, input bit se,
                                      input bit fd, input bit fe, input bit fm,
                                      input bit busy, input bit done);
      return {fa, fb, sf, sd, se, fd, fe, fm, busy, done};
   endfunction

   task automatic chk(input string nm, input bit sel, input logic [11:0] e);
      exp_t x;
      x.name = nm;
      x.sel  = sel;
      x.exp  = e;
      q.push_back(x);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      m_if.RA1D = '0; m_if.RA2D = '0; m_if.RA1E = '0; m_if.RA2E = '0;
      m_if.WA3E = '0; m_if.WA3M = '0; m_if.WA3W = '0;
      m_if.RegWriteM = 0; m_if.RegWriteW = 0; m_if.MemtoRegE = 0;
      m_if.MulStartE = 0; m_if.BranchTakenE = 0; m_if.PCWrPendingF = 0; m_if.PCSrcW = 0;
      s_if.RA1D = '0; s_if.RA2D = '0; s_if.RA1E = '0; s_if.RA2E = '0;
      s_if.WA3E = '0; s_if.WA3M = '0; s_if.WA3W = '0;
      s_if.RegWriteM = 0; s_if.RegWriteW = 0; s_if.MemtoRegE = 0;
      s_if.MulStartE = 0; s_if.BranchTakenE = 0; s_if.PCWrPendingF = 0; s_if.PCSrcW = 0;
   endtask

   // Four cycles of a MUL_LAT=4 multiply with MulStartE held high.
   task automatic mul_seq(input string nm);
      m_if.MulStartE = 1;
      chk({nm, "_c0"}, 0, ev(2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 0, 0));
      cyc(); chk({nm, "_c1"}, 0, ev(2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 1, 0));
      cyc(); chk({nm, "_c2"}, 0, ev(2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 1, 0));
      cyc(); chk({nm, "_c3"}, 0, ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1));
      cyc(); m_if.MulStartE = 0;
      chk({nm, "_idle"}, 0, ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
   endtask

   initial begin
      clr();
      reset = 1;
      // Inputs that would otherwise forward, stall and flush: reset must mask them all.
      m_if.RA1E = 4'd3; m_if.WA3M = 4'd3; m_if.RegWriteM = 1;
      m_if.MemtoRegE = 1; m_if.BranchTakenE = 1; m_if.PCWrPendingF = 1;
      cyc(); chk("reset_quiet", 0, ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
      cyc(); reset = 0; clr();

      // Forwarding priority M over W
      m_if.RA1E = 4'd3; m_if.RA2E = 4'd7; m_if.WA3M = 4'd3; m_if.WA3W = 4'd3;
      m_if.RegWriteM = 1; m_if.RegWriteW = 1;
      chk("fwd_a_m", 0, ev(2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
      cyc(); m_if.RegWriteM = 0;
      chk("fwd_a_w", 0, ev(2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
      cyc(); m_if.RegWriteW = 0;
      chk("fwd_a_rf", 0, ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
      cyc(); m_if.RA1E = 4'd9; m_if.RA2E = 4'd9; m_if.WA3M = 4'd9; m_if.WA3W = 4'd9;
      m_if.RegWriteM = 1; m_if.RegWriteW = 1;
      chk("fwd_ab_m", 0, ev(2'b10, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0));
      // Full-width compare: 1001 must not match 0001
      cyc(); m_if.RA1E = 4'd1; m_if.RA2E = 4'd9; m_if.WA3M = 4'd0; m_if.RegWriteM = 0;
      m_if.WA3W = 4'd1; m_if.RegWriteW = 1;
      chk("fwd_fullwidth", 0, ev(2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
      cyc(); m_if.RA1E = 4'd2; m_if.WA3W = 4'd6; m_if.RA2E = 4'd6;
      chk("fwd_b_w", 0, ev(2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0));

      // Load-use
      cyc(); clr(); m_if.MemtoRegE = 1; m_if.WA3E = 4'd5; m_if.RA2D = 4'd5; m_if.RA1D = 4'd0;
      chk("ldr_ra2", 0, ev(2'b00, 2'b00, 1, 1, 0, 0, 1, 0, 0, 0));
      cyc(); m_if.RA2D = 4'd6;
      chk("ldr_nomatch", 0, ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
      cyc(); m_if.RA1D = 4'd5;
      chk("ldr_ra1", 0, ev(2'b00, 2'b00, 1, 1, 0, 0, 1, 0, 0, 0));

      // Branch / PC write
      cyc(); clr(); m_if.RA1D = 4'd1; m_if.RA2D = 4'd2; m_if.WA3E = 4'd3;
      m_if.BranchTakenE = 1;
      chk("branch", 0, ev(2'b00, 2'b00, 0, 0, 0, 1, 1, 0, 0, 0));
      cyc(); m_if.BranchTakenE = 0; m_if.PCWrPendingF = 1;
      chk("pcwr_pend", 0, ev(2'b00, 2'b00, 1, 1, 0, 1, 0, 0, 0, 0));
      cyc(); m_if.PCWrPendingF = 0; m_if.PCSrcW = 1;
      chk("pcsrcw", 0, ev(2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 0, 0));

      // Plain multiply
      cyc(); m_if.PCSrcW = 0;
      mul_seq("mul");

      // Multiply with load-use in D, branch on the start cycle
      cyc(); m_if.MemtoRegE = 1; m_if.WA3E = 4'd5; m_if.RA2D = 4'd5; m_if.RA1D = 4'd0;
      m_if.MulStartE = 1; m_if.BranchTakenE = 1;
      chk("mul_ldr_c0", 0, ev(2'b00, 2'b00, 1, 1, 1, 1, 0, 1, 0, 0));
      cyc(); m_if.BranchTakenE = 0;
      chk("mul_ldr_c1", 0, ev(2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 1, 0));
      cyc(); chk("mul_ldr_c2", 0, ev(2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 1, 0));
      cyc(); chk("mul_ldr_c3", 0, ev(2'b00, 2'b00, 1, 1, 0, 0, 1, 0, 1, 1));
      cyc(); clr();
      chk("mul_ldr_idle", 0, ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));

      // Reset during a multiply
      cyc(); m_if.MulStartE = 1;
      chk("rst_mul_c0", 0, ev(2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 0, 0));
      cyc(); reset = 1;
      chk("rst_mul_held", 0, ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
      cyc(); reset = 0; m_if.MulStartE = 0;
      chk("rst_mul_after", 0, ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
      cyc(); mul_seq("mul_fresh");

      // MUL_LAT=1 instance
      cyc(); s_if.MulStartE = 1;
      chk("lat1_done", 1, ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1));
      cyc(); chk("lat1_again", 1, ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1));
      cyc(); s_if.MulStartE = 0;
      chk("lat1_idle", 1, ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));

      repeat (3) @(posedge clk);
      if (q.size() != 0) begin
         n_errors++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
